// File: rtl/sample_pacer.sv
// Sample pacer: FIFO-buffered samples leave as a one-cycle out_ready strobe every PERIOD clocks; wr_ready drops only when full.
// Build option SAMPLE_PACER_HOLD_LAST_EN repeats the last sample on underflow instead of emitting silence.
module sample_pacer #(
  parameter int DEPTH  = 8,
  parameter int PERIOD = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [15:0]       wr_data,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  output logic signed [15:0]       sample_out,
  output logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = $clog2(PERIOD);

  logic signed [15:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [PW-1:0]      pcnt;
  logic               tick;
  logic               push;
  logic               pop;

  assign wr_ready = (count != CW'(DEPTH));
  assign tick     = (pcnt == PW'(PERIOD - 1));
  // reset gate keeps the storage array untouched while the block is held in reset
  assign push     = wr_valid && wr_ready && reset;
  assign pop      = tick && (count != '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcnt       <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      sample_out <= 16'sd0;
      out_ready  <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      pcnt <= tick ? '0 : pcnt + PW'(1);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      out_ready <= tick;
      underflow <= tick && (count == '0);
      if (pop) begin
        sample_out <= mem[rd_ptr];
      end else if (tick) begin
`ifdef SAMPLE_PACER_HOLD_LAST_EN
        sample_out <= sample_out;
`else
        sample_out <= 16'sd0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_sample_pacer.sv
// Bench for sample_pacer (PERIOD=4, DEPTH=8); honours SAMPLE_PACER_HOLD_LAST_EN when defined for the build.
module tb_sample_pacer;

  localparam int DEPTH  = 8;
  localparam int PERIOD = 4;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic signed [15:0] wr_data = '0;
  logic               wr_valid = 1'b0;
  logic               wr_ready;
  logic signed [15:0] sample_out;
  logic               out_ready;
  logic [3:0]         count;
  logic               underflow;

  int total = 0;
  int bad   = 0;

  // reference model: a queue of pending samples plus an edge counter since reset release
  logic signed [15:0] q [$];
  logic signed [15:0] exp_sample;
  logic               exp_or;
  logic               exp_uf;
  int                 edge_idx;

  sample_pacer #(.DEPTH(DEPTH), .PERIOD(PERIOD)) dut (
    .clk(clk), .reset(reset), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .sample_out(sample_out), .out_ready(out_ready),
    .count(count), .underflow(underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    edge_idx   = 0;
    exp_sample = 16'sd0;
    exp_or     = 1'b0;
    exp_uf     = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".count"}, 32'(count), 32'(q.size()));
    chk({tag, ".out_ready"}, 32'(out_ready), 32'(exp_or));
    chk({tag, ".underflow"}, 32'(underflow), 32'(exp_uf));
    chk({tag, ".sample_out"}, 32'(sample_out), 32'(exp_sample));
  endtask

  // one clock: drive inputs, advance model by the spec's rules, compare just after the edge
  task automatic step(input logic v, input logic [15:0] d);
    bit tick, push, pop;
    wr_valid = v;
    wr_data  = d;
    chk("wr_ready", 32'(wr_ready), 32'(q.size() != DEPTH));
    @(posedge clk);
    edge_idx++;
    tick = (edge_idx % PERIOD) == 0;
    push = v && (q.size() < DEPTH);
    pop  = tick && (q.size() > 0);
    exp_or = tick;
    exp_uf = tick && !pop;
    if (pop) exp_sample = q.pop_front();
`ifndef SAMPLE_PACER_HOLD_LAST_EN
    else if (tick) exp_sample = 16'sd0;
`endif
    if (push) q.push_back(d);
    #1;
    check_outputs("step");
  endtask

  task automatic idle_until_empty();
    for (int i = 0; i < 200 && q.size() != 0; i++) step(1'b0, 16'h0);
  endtask

  initial begin
    logic [15:0] last_sample;

    // reset held low for 3 cycles, with a producer offering data that must be ignored
    model_reset();
    wr_valid = 1'b1;
    wr_data  = 16'h5555;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.wr_ready", 32'(wr_ready), 32'd1);
    check_outputs("rst");
    wr_valid = 1'b0;
    reset    = 1'b1;

    // strobe cadence with an empty FIFO
    for (int i = 0; i < 12; i++) step(1'b0, 16'h0);

    // burst of boundary values
    step(1'b1, 16'h7FFF);
    step(1'b1, 16'h8000);
    step(1'b1, 16'h0001);
    idle_until_empty();
    step(1'b0, 16'h0);

    // continuous push to fill and hold the FIFO full
    for (int i = 0; i < 60; i++) step(1'b1, 16'($urandom));
    chk("full.count", 32'(count), 32'(DEPTH));
    idle_until_empty();

    // drain to empty with last sample 0x1234, then wait for the underflow tick
    step(1'b1, 16'h1234);
    idle_until_empty();
    while ((edge_idx + 1) % PERIOD != 0) step(1'b0, 16'h0);
    step(1'b0, 16'h0);
    last_sample = 16'h1234;
    chk("uflow.underflow", 32'(underflow), 32'd1);
`ifdef SAMPLE_PACER_HOLD_LAST_EN
    chk("uflow.sample", 32'(sample_out), 32'(last_sample));
`else
    chk("uflow.sample", 32'(sample_out), 32'h0);
`endif

    // push into empty FIFO exactly on the tick edge
    while ((edge_idx + 1) % PERIOD != 0) step(1'b0, 16'h0);
    step(1'b1, 16'h0042);
    chk("pushpop.underflow", 32'(underflow), 32'd1);
    for (int i = 0; i < PERIOD; i++) step(1'b0, 16'h0);
    chk("pushpop.sample", 32'(sample_out), 32'h0042);
    chk("pushpop.nouf", 32'(underflow), 32'd0);

    // randomized traffic
    for (int i = 0; i < 300; i++) step(1'(($urandom % 3) == 0), 16'($urandom));
    idle_until_empty();

    // load 5 words, then reset mid-period
    while (edge_idx % PERIOD != 0) step(1'b0, 16'h0);
    for (int i = 0; i < 5; i++) step(1'b1, 16'($urandom));
    step(1'b0, 16'h0);
    reset = 1'b0;
    #2;
    model_reset();
    chk("midrst.wr_ready", 32'(wr_ready), 32'd1);
    check_outputs("midrst");
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < PERIOD; i++) step(1'b0, 16'h0);
    chk("midrst.uf", 32'(underflow), 32'd1);
    for (int i = 0; i < 20; i++) step(1'(($urandom % 2) == 0), 16'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sample_pacer.md
# sample_pacer

Sample-rate pacing transmitter for the synth datapath. It buffers signed 16-bit samples from a bursty upstream producer (note/wave generator, host loader) in a small FIFO. It emits them at a fixed cadence as a one-cycle `out_ready` strobe with `sample_out`, which is exactly the `sample_in`/`in_ready` strobe protocol the `adsr` envelope stage consumes. It sits immediately upstream of `adsr` and guarantees that stage a regular sample clock regardless of producer jitter.

## Interface
- `DEPTH`, default 8: FIFO entries; power of two, ≥2.
- `PERIOD`, default 4: clocks between output strobes; ≥2.
- `clk`  in  1: system clock, all logic on rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `wr_data`  in  16: signed sample from the producer.
- `wr_valid`  in  1: producer offers `wr_data` this cycle.
- `wr_ready`  out  1: FIFO can accept; a push occurs on an edge where `wr_valid && wr_ready`.
- `sample_out`  out  16: signed sample to `adsr.sample_in`; registered.
- `out_ready`  out  1: one-cycle strobe to `adsr.in_ready`; registered.
- `count`  out  $clog2(DEPTH)+1: current FIFO occupancy, 0..DEPTH.
- `underflow`  out  1: one-cycle pulse when a strobe fires with the FIFO empty.

## Operation
- Storage: circular buffer with `DEPTH` entries and wrapping read/write pointers.
  - Pointers are $clog2(DEPTH) bits, so wrap is natural.
  - `count` is kept as a separate register.
- `wr_ready = (count != DEPTH)`, combinational from `count`. It is high during reset.
  - Pushes are ignored while `reset` is low.
- Pacing counter `pcnt`: 0..PERIOD-1.
  - Increments every clock and wraps from PERIOD-1 to 0.
  - A tick occurs on the edge where `pcnt == PERIOD-1`.
- On a tick with `count > 0`:
  - Pop the head into `sample_out`.
  - `out_ready <= 1`.
- On a tick with `count == 0`:
  - `out_ready <= 1` and `underflow <= 1`.
  - `sample_out` is set per the Configuration section.
- On a non-tick edge:
  - `out_ready <= 0`, `underflow <= 0`.
  - `sample_out` holds its value.
- Push and pop on the same edge:
  - `count` is unchanged and both pointers advance.
  - Pop uses the pre-edge `count`. A push into an empty FIFO on a tick edge therefore does not satisfy that tick: underflow fires and the pushed word stays queued.
- Full FIFO (`count == DEPTH`): the push is refused because `wr_ready` is low. A pop on that edge frees one slot for the next cycle.
- `wr_data` is stored verbatim; there is no arithmetic on sample values.

## Timing
- Reset (`reset` low) forces, asynchronously:
  - `pcnt = 0`, pointers = 0, `count = 0`.
  - `sample_out = 16'sd0`, `out_ready = 0`, `underflow = 0`.
- After reset release, the first tick is the PERIOD-th rising edge. `out_ready` is high for the following cycle, then repeats every PERIOD cycles.
- Latency: a word pushed at edge k appears on `sample_out` at the first tick edge ≥ k+1, as long as no older words are queued.
- `count` updates on the push/pop edge. `wr_ready` follows it in the same cycle.
- Reset asserted mid-operation discards FIFO contents immediately and restarts pacing from `pcnt = 0`.

## Configuration
- Macro: `SAMPLE_PACER_HOLD_LAST_EN`.
- Defined: on an underflow tick, `sample_out` keeps its previous value, so the last sample is repeated.
- Undefined: on an underflow tick, `sample_out <= 16'sd0` (silence).
- `underflow` and `out_ready` behave identically in both builds.

## Test plan
All scenarios use PERIOD=4 and DEPTH=8.

1. **Reset values.** Hold `reset` low for 3 cycles -> all outputs 0, `wr_ready` = 1, `count` = 0.
   - After release, the first `out_ready` pulse follows the 4th edge.
   - Pulses then repeat every 4 cycles, each 1 cycle wide.
2. **Burst fill.** Push 0x7FFF, 0x8000, 0x0001 back-to-back.
   - The next three strobes carry 0x7FFF, 0x8000, 0x0001 in order.
   - `count` reads 3→2→1→0 as they drain.
3. **Full FIFO.** Push continuously with `wr_valid` = 1.
   - `count` reaches 8 and `wr_ready` drops.
   - Each tick pops one word; `wr_ready` rises for one cycle and refills the slot.
   - Output order matches input order; no word is lost or duplicated.
4. **Underflow.** Drain to empty with last sample 0x1234; the next tick gives `underflow` = 1 and `out_ready` = 1.
   - With `SAMPLE_PACER_HOLD_LAST_EN`: `sample_out` = 0x1234.
   - Without it: `sample_out` = 0x0000.
5. **Simultaneous push/pop on empty.** Push 0x0042 on the tick edge with `count` = 0.
   - That tick underflows.
   - The next tick emits 0x0042 with `underflow` = 0.
6. **Mid-operation reset.** Load 5 words, then pulse `reset` low for 1 cycle mid-period.
   - All outputs clear asynchronously and `count` = 0.
   - The next strobe arrives 4 edges after release and underflows.
